// File: rtl/alu_op_sequencer_if.sv
// Op request handshake between a requester (master) and the ALU op sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int FUNC_W     = 3,
  parameter int REG_ADDR_W = 2
);
  logic                  op_valid;
  logic                  op_ready;
  logic [FUNC_W-1:0]     op_func;
  logic [REG_ADDR_W-1:0] op_rs1;
  logic [REG_ADDR_W-1:0] op_rs2;
  logic [REG_ADDR_W-1:0] op_rd;
  logic                  op_wb_en;

  modport master (
    output op_valid, op_func, op_rs1, op_rs2, op_rd, op_wb_en,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_func, op_rs1, op_rs2, op_rd, op_wb_en,
    output op_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Four-phase controller (accept/read/execute/write-back) driving an external
// register file and ALU, one op per handshake, with registered outputs.
module alu_op_sequencer #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_REGS   = 4,
  parameter int REG_ADDR_W = 2,
  parameter int FUNC_W     = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_op_sequencer_if.slave     op_if,
  output logic [REG_ADDR_W-1:0] rf_rd_addr1,
  output logic [REG_ADDR_W-1:0] rf_rd_addr2,
  input  logic [WORD_SIZE-1:0]  rf_rd_data1,
  input  logic [WORD_SIZE-1:0]  rf_rd_data2,
  output logic [WORD_SIZE-1:0]  alu_a,
  output logic [WORD_SIZE-1:0]  alu_b,
  output logic [FUNC_W-1:0]     alu_func,
  input  logic [WORD_SIZE-1:0]  alu_result,
  input  logic                  alu_overflow,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [WORD_SIZE-1:0]  rf_wr_data,
  output logic                  done,
  output logic [WORD_SIZE-1:0]  result,
  output logic                  overflow,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [FUNC_W-1:0]     r_func;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_wb_en;

  assign op_if.op_ready = r_ready;

  // Each output is set one edge ahead of the state in which it is meaningful,
  // so the state's outputs come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_func      <= '0;
      r_rd        <= '0;
      r_wb_en     <= 1'b0;
      rf_rd_addr1 <= '0;
      rf_rd_addr2 <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_func    <= '0;
      rf_we       <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      op_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_if.op_valid) begin
            r_func      <= op_if.op_func;
            r_rd        <= op_if.op_rd;
            r_wb_en     <= op_if.op_wb_en;
            rf_rd_addr1 <= op_if.op_rs1;
            rf_rd_addr2 <= op_if.op_rs2;
            r_ready     <= 1'b0;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          alu_a    <= rf_rd_data1;
          alu_b    <= rf_rd_data2;
          alu_func <= r_func;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          rf_we      <= r_wb_en;
          rf_wr_addr <= r_rd;
          rf_wr_data <= alu_result;
          result     <= alu_result;
          overflow   <= alu_overflow;
          done       <= 1'b1;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          rf_we    <= 1'b0;
          done     <= 1'b0;
          op_count <= op_count + CNT_W'(1);
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: register file and ALU models around the DUT,
// a queue-based reference model checked every cycle, plus directed literals.
module tb_alu_op_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [15:0] w_rd_data1, w_rd_data2;
  logic [15:0] alu_a, alu_b, w_alu_result, rf_wr_data, result;
  logic [2:0]  alu_func;
  logic        w_alu_ovf, rf_we, done, overflow;
  logic [7:0]  op_count;

  logic [15:0] r_rf [4];
  logic [15:0] r_model_regs [4];
  logic [7:0]  r_model_cnt;
  int          n_vec;
  int          n_fail;
  int          cyc;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic [1:0]  rd;
    logic        wb;
    int          acc;
  } exp_t;
  exp_t q[$];

  alu_op_sequencer_if #(.FUNC_W(3), .REG_ADDR_W(2)) bus ();

  alu_op_sequencer dut (
    .clk(clk), .reset_n(reset_n), .op_if(bus),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(w_rd_data1), .rf_rd_data2(w_rd_data2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(w_alu_result), .alu_overflow(w_alu_ovf),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .done(done), .result(result), .overflow(overflow), .op_count(op_count)
  );

  // 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 PASS-A
  function automatic logic [16:0] alu_fn(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (f)
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << 1;
      3'd6: r = a >> 1;
      default: r = a;
    endcase
    return {v, r};
  endfunction

  assign w_rd_data1 = r_rf[rf_rd_addr1];
  assign w_rd_data2 = r_rf[rf_rd_addr2];
  assign {w_alu_ovf, w_alu_result} = alu_fn(alu_func, alu_a, alu_b);

  always @(posedge clk) if (rf_we) r_rf[rf_wr_addr] <= rf_wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an op is in flight from acceptance until its done cycle,
  // which must fall on the third falling edge after the accepting one.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      r_model_cnt = '0;
    end else begin
      chk("op_ready", {31'd0, bus.op_ready}, {31'd0, q.size() == 0});
      chk("op_count", {24'd0, op_count}, {24'd0, r_model_cnt});
      if (q.size() > 0) begin
        chk("done", {31'd0, done}, {31'd0, cyc == q[0].acc + 3});
        chk("rf_we", {31'd0, rf_we}, {31'd0, (cyc == q[0].acc + 3) && q[0].wb});
      end else begin
        chk("done_idle", {31'd0, done}, 32'd0);
        chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
        for (int i = 0; i < 4; i++) chk("regfile", {16'd0, r_rf[i]}, {16'd0, r_model_regs[i]});
      end
      if (done && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        chk("rf_wr_data", {16'd0, rf_wr_data}, {16'd0, e.res});
        chk("rf_wr_addr", {30'd0, rf_wr_addr}, {30'd0, e.rd});
        if (e.wb) r_model_regs[e.rd] = e.res;
        r_model_cnt = r_model_cnt + 8'd1;
      end
      if (bus.op_valid && bus.op_ready) begin
        exp_t e;
        logic [16:0] ar;
        ar = alu_fn(bus.op_func, r_model_regs[bus.op_rs1], r_model_regs[bus.op_rs2]);
        e.res = ar[15:0];
        e.ovf = ar[16];
        e.rd  = bus.op_rd;
        e.wb  = bus.op_wb_en;
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic set_regs(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3);
    r_rf[0] = v0; r_rf[1] = v1; r_rf[2] = v2; r_rf[3] = v3;
    r_model_regs[0] = v0; r_model_regs[1] = v1; r_model_regs[2] = v2; r_model_regs[3] = v3;
  endtask

  // Returns #1 after the accepting edge with op_valid dropped.
  task automatic do_op(input logic [2:0] f, input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd, input logic wb);
    bit ok;
    ok = 1'b0;
    bus.op_func = f; bus.op_rs1 = rs1; bus.op_rs2 = rs2; bus.op_rd = rd; bus.op_wb_en = wb;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.op_ready) ok = 1'b1;
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_func  = 3'($urandom_range(0, 7));
    bus.op_rs1   = 2'($urandom_range(0, 3));
    bus.op_rs2   = 2'($urandom_range(0, 3));
    bus.op_rd    = 2'($urandom_range(0, 3));
    bus.op_wb_en = 1'($urandom_range(0, 1));
  endtask

  // Counts falling edges until done; called right after do_op returns.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    chk("done_timeout", {31'd0, lat != 0}, 32'd1);
  endtask

  initial begin
    int lat;
    n_vec = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0;
    bus.op_valid = 1'b0; bus.op_func = '0; bus.op_rs1 = '0; bus.op_rs2 = '0;
    bus.op_rd = '0; bus.op_wb_en = 1'b0;
    set_regs(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, bus.op_ready}, 32'd1);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_we", {31'd0, rf_we}, 32'd0);
      chk("idle_cnt", {24'd0, op_count}, 32'd0);
    end

    @(posedge clk); #1;
    set_regs(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    do_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1);
    wait_done(lat);
    chk("add_latency", lat, 32'd3);
    chk("add_result", {16'd0, result}, 32'h0020);
    @(posedge clk); #1;
    chk("add_r2", {16'd0, r_rf[2]}, 32'h0020);
    chk("add_cnt", {24'd0, op_count}, 32'd1);

    set_regs(16'h7FFF, 16'h0001, 16'h0000, 16'h0000);
    do_op(3'd0, 2'd0, 2'd1, 2'd3, 1'b1);
    wait_done(lat);
    chk("ovf_result", {16'd0, result}, 32'h8000);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    @(posedge clk); #1;
    chk("ovf_r3", {16'd0, r_rf[3]}, 32'h8000);

    set_regs(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    do_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1);
    do_op(3'd0, 2'd2, 2'd2, 2'd1, 1'b1);
    wait_done(lat);
    chk("b2b_latency", lat, 32'd3);
    chk("b2b_result", {16'd0, result}, 32'h0040);
    @(posedge clk); #1;
    chk("b2b_r1", {16'd0, r_rf[1]}, 32'h0040);

    set_regs(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    do_op(3'd0, 2'd0, 2'd1, 2'd0, 1'b0);
    wait_done(lat);
    chk("nowb_result", {16'd0, result}, 32'h0020);
    @(posedge clk); #1;
    chk("nowb_r0", {16'd0, r_rf[0]}, 32'h0010);
    chk("cnt_before_rst", {24'd0, op_count}, 32'd5);

    do_op(3'd1, 2'd0, 2'd1, 2'd3, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("rst_cnt", {24'd0, op_count}, 32'd0);
    chk("rst_r3", {16'd0, r_rf[3]}, 32'h0010);
    repeat (4) @(negedge clk);

    for (int n = 0; n < 256; n++) begin
      if (n % 64 == 0) begin
        @(posedge clk); #1;
        if (!bus.op_ready) @(negedge clk);
        set_regs(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end
      do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (n % 64 == 63) wait_done(lat);
    end
    @(negedge clk);
    chk("wrap_cnt", {24'd0, op_count}, 32'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
